// File: rtl/nios_sys_led_fader_if.sv
// Bundle between the LED PIO side and the fader: target pattern and mode in,
// PWM drive and ramp status out.
interface nios_sys_led_fader_if;
    logic       enable;
    logic [7:0] pattern_in;
    logic [7:0] led_out;
    logic       busy;

    modport master (output enable, pattern_in, input  led_out, busy);
    modport slave  (input  enable, pattern_in, output led_out, busy);
endinterface

// File: rtl/nios_sys_led_fader.sv
// Per-LED PWM fader: each PIO bit ramps its channel brightness toward full-on
// or full-off once per PWM period; enable=0 bypasses straight to the pattern.
//
//   state   | meaning
//   --------+----------------------------------------------
//   ST_OFF  | brightness 0, parked
//   ST_RISE | stepping up by FADE_STEP each PWM period
//   ST_ON   | brightness 255, parked
//   ST_FALL | stepping down by FADE_STEP each PWM period
module nios_sys_led_fader #(
    parameter int PRESCALE   = 4,
    parameter int FADE_STEP  = 16,
    parameter bit INVERT_OUT = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    nios_sys_led_fader_if.slave   io_bus
);

    localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX   = PS_W'(PRESCALE - 1);
    localparam logic [8:0]      STEP9    = 9'(FADE_STEP);
    localparam logic [7:0]      INV_MASK = {8{INVERT_OUT}};

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } state_t;

    logic [7:0]      r_pattern;
    logic [PS_W-1:0] r_prescale;
    logic [7:0]      r_pwm_cnt;
    logic [7:0]      r_bright [8];
    state_t          r_state  [8];
    logic [7:0]      r_led;
    logic            r_busy;

    logic            w_tick;
    logic            w_period_end;
    logic [8:0]      w_sum      [8];
    logic [8:0]      w_dif      [8];
    logic [7:0]      w_inc      [8];
    logic [7:0]      w_dec      [8];
    logic [7:0]      w_bright_nxt [8];
    state_t          w_state_nxt  [8];
    logic [7:0]      w_raw;
    logic            w_any_ramp;

    assign w_tick       = io_bus.enable && (r_prescale == PS_MAX);
    assign w_period_end = w_tick && (r_pwm_cnt == 8'hFF);

    // 9-bit arithmetic; bit 8 flags overflow/borrow and selects the clamp value
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_sum[i] = {1'b0, r_bright[i]} + STEP9;
            w_dif[i] = {1'b0, r_bright[i]} - STEP9;
            w_inc[i] = w_sum[i][8] ? 8'hFF : w_sum[i][7:0];
            w_dec[i] = w_dif[i][8] ? 8'h00 : w_dif[i][7:0];
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_bright_nxt[i] = r_bright[i];
            w_state_nxt[i]  = r_state[i];
            if (!io_bus.enable) begin
                w_bright_nxt[i] = r_pattern[i] ? 8'hFF : 8'h00;
                w_state_nxt[i]  = r_pattern[i] ? ST_ON : ST_OFF;
            end else if (w_period_end) begin
                case (r_state[i])
                    ST_OFF: begin
                        if (r_pattern[i]) begin
                            w_bright_nxt[i] = w_inc[i];
                            w_state_nxt[i]  = (w_inc[i] == 8'hFF) ? ST_ON : ST_RISE;
                        end
                    end
                    ST_ON: begin
                        if (!r_pattern[i]) begin
                            w_bright_nxt[i] = w_dec[i];
                            w_state_nxt[i]  = (w_dec[i] == 8'h00) ? ST_OFF : ST_FALL;
                        end
                    end
                    default: begin
                        if (r_pattern[i]) begin
                            w_bright_nxt[i] = w_inc[i];
                            w_state_nxt[i]  = (w_inc[i] == 8'hFF) ? ST_ON : ST_RISE;
                        end else begin
                            w_bright_nxt[i] = w_dec[i];
                            w_state_nxt[i]  = (w_dec[i] == 8'h00) ? ST_OFF : ST_FALL;
                        end
                    end
                endcase
            end
        end
    end

    // Full brightness is forced high so 255 never shows the one-count gap
    always_comb begin
        w_raw      = '0;
        w_any_ramp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_raw[i] = (r_bright[i] == 8'hFF) || (r_bright[i] > r_pwm_cnt);
            if ((r_state[i] == ST_RISE) || (r_state[i] == ST_FALL)) begin
                w_any_ramp = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pattern  <= '0;
            r_prescale <= '0;
            r_pwm_cnt  <= '0;
            r_led      <= INV_MASK;
            r_busy     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_bright[i] <= '0;
                r_state[i]  <= ST_OFF;
            end
        end else begin
            r_pattern <= io_bus.pattern_in;
            if (!io_bus.enable || w_tick) begin
                r_prescale <= '0;
            end else begin
                r_prescale <= r_prescale + PS_W'(1);
            end
            if (!io_bus.enable) begin
                r_pwm_cnt <= '0;
            end else if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end
            for (int i = 0; i < 8; i++) begin
                r_bright[i] <= w_bright_nxt[i];
                r_state[i]  <= w_state_nxt[i];
            end
            r_busy <= io_bus.enable && w_any_ramp;
            r_led  <= (io_bus.enable ? w_raw : r_pattern) ^ INV_MASK;
        end
    end

    assign io_bus.led_out = r_led;
    assign io_bus.busy    = r_busy;

endmodule

// File: tb/tb_nios_sys_led_fader.sv
// Four fader configurations driven by one shared stimulus stream; a brightness
// reference model feeds an expectation queue drained by an independent monitor.
module tb_nios_sys_led_fader;

    typedef struct packed {
        logic [3:0][7:0] led;
        logic [3:0]      busy;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] pat;

    int n_vec;
    int n_err;

    nios_sys_led_fader_if bus0();
    nios_sys_led_fader_if bus1();
    nios_sys_led_fader_if bus2();
    nios_sys_led_fader_if bus3();

    assign bus0.enable = en;  assign bus0.pattern_in = pat;
    assign bus1.enable = en;  assign bus1.pattern_in = pat;
    assign bus2.enable = en;  assign bus2.pattern_in = pat;
    assign bus3.enable = en;  assign bus3.pattern_in = pat;

    nios_sys_led_fader #(.PRESCALE(1), .FADE_STEP(64),  .INVERT_OUT(1'b0)) u_dut0 (.clk(clk), .reset(rst), .io_bus(bus0));
    nios_sys_led_fader #(.PRESCALE(1), .FADE_STEP(64),  .INVERT_OUT(1'b1)) u_dut1 (.clk(clk), .reset(rst), .io_bus(bus1));
    nios_sys_led_fader #(.PRESCALE(4), .FADE_STEP(16),  .INVERT_OUT(1'b0)) u_dut2 (.clk(clk), .reset(rst), .io_bus(bus2));
    nios_sys_led_fader #(.PRESCALE(2), .FADE_STEP(255), .INVERT_OUT(1'b0)) u_dut3 (.clk(clk), .reset(rst), .io_bus(bus3));

    logic [7:0] dut_led  [4];
    logic       dut_busy [4];
    assign dut_led[0] = bus0.led_out;  assign dut_busy[0] = bus0.busy;
    assign dut_led[1] = bus1.led_out;  assign dut_busy[1] = bus1.busy;
    assign dut_led[2] = bus2.led_out;  assign dut_busy[2] = bus2.busy;
    assign dut_led[3] = bus3.led_out;  assign dut_busy[3] = bus3.busy;

    // configuration of each instance, as seen by the model
    int cp [4];
    int cs [4];
    bit ci [4];

    // model: per-instance prescaler, PWM count, brightness, registered outputs
    int         m_pre  [4];
    int         m_pwm  [4];
    int         m_b    [4][8];
    logic [7:0] m_pat  [4];
    logic [7:0] m_led  [4];
    bit         m_busy [4];

    exp_t q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_step(input bit r, input bit e, input logic [7:0] p);
        exp_t x;
        x = '0;
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                m_pre[k]  = 0;
                m_pwm[k]  = 0;
                m_pat[k]  = 8'h00;
                m_busy[k] = 1'b0;
                m_led[k]  = ci[k] ? 8'hFF : 8'h00;
                for (int i = 0; i < 8; i++) m_b[k][i] = 0;
            end else begin
                logic [7:0] led_n;
                bit         mid;
                bit         tick;
                bit         pe;
                mid = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (m_b[k][i] != 0 && m_b[k][i] != 255) mid = 1'b1;
                    if (e) led_n[i] = (m_b[k][i] == 255) || (m_b[k][i] > m_pwm[k]);
                    else   led_n[i] = m_pat[k][i];
                end
                if (ci[k]) led_n = ~led_n;
                tick = e && (m_pre[k] == cp[k] - 1);
                pe   = tick && (m_pwm[k] == 255);
                for (int i = 0; i < 8; i++) begin
                    if (!e) begin
                        m_b[k][i] = m_pat[k][i] ? 255 : 0;
                    end else if (pe) begin
                        if (m_pat[k][i]) m_b[k][i] = (m_b[k][i] + cs[k] > 255) ? 255 : m_b[k][i] + cs[k];
                        else             m_b[k][i] = (m_b[k][i] - cs[k] < 0)   ? 0   : m_b[k][i] - cs[k];
                    end
                end
                m_pre[k]  = !e ? 0 : (tick ? 0 : m_pre[k] + 1);
                m_pwm[k]  = !e ? 0 : (tick ? (m_pwm[k] + 1) % 256 : m_pwm[k]);
                m_pat[k]  = p;
                m_led[k]  = led_n;
                m_busy[k] = e && mid;
            end
            x.led[k]  = m_led[k];
            x.busy[k] = m_busy[k];
        end
        q.push_back(x);
    endtask

    task automatic cyc(input bit r, input bit e, input logic [7:0] p);
        @(negedge clk);
        #1;
        rst = r;
        en  = e;
        pat = p;
        model_step(r, e, p);
    endtask

    task automatic hold(input bit e, input logic [7:0] p, input int n);
        repeat (n) cyc(1'b0, e, p);
    endtask

    // reset asserted between edges must reach the outputs without a clock
    task automatic async_reset_check();
        @(negedge clk);
        #1;
        rst = 1'b1;
        pat = 8'hFF;
        model_step(1'b1, en, 8'hFF);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (dut_led[k] !== m_led[k] || dut_busy[k] !== 1'b0) begin
                n_err++;
                $display("FAIL async_reset dut%0d: led=%h busy=%b, required led=%h busy=0",
                         k, dut_led[k], dut_busy[k], m_led[k]);
            end
        end
    endtask

    // monitor: one output sample per cycle per instance
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                x = q.pop_front();
                for (int k = 0; k < 4; k++) begin
                    n_vec++;
                    if (dut_led[k] !== x.led[k] || dut_busy[k] !== x.busy[k]) begin
                        n_err++;
                        $display("FAIL out_dut%0d t=%0t: led=%h busy=%b, required led=%h busy=%b",
                                 k, $time, dut_led[k], dut_busy[k], x.led[k], x.busy[k]);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] rp;
        int         rn;
        bit         re;
        n_vec = 0;
        n_err = 0;
        cp = '{1, 1, 4, 2};
        cs = '{64, 64, 16, 255};
        ci = '{1'b0, 1'b1, 1'b0, 1'b0};
        rst = 1'b1;
        en  = 1'b1;
        pat = 8'hFF;

        repeat (4) cyc(1'b1, 1'b1, 8'hFF);
        // ramp then reversal at 128, then full ramp up and down
        hold(1'b1, 8'h01, 600);
        hold(1'b1, 8'h00, 800);
        hold(1'b1, 8'h01, 1300);
        hold(1'b1, 8'h00, 1300);
        // saturation on every channel
        hold(1'b1, 8'hFF, 700);
        hold(1'b1, 8'h00, 700);
        // bypass and re-enable with no ramp
        hold(1'b0, 8'hA5, 20);
        hold(1'b1, 8'hA5, 700);
        hold(1'b0, 8'h3C, 5);
        hold(1'b1, 8'h3C, 300);
        // slow-fade instance through a complete ramp
        hold(1'b1, 8'hFF, 16800);
        hold(1'b1, 8'h00, 5000);
        // mid-ramp reset
        hold(1'b1, 8'h5A, 700);
        async_reset_check();
        repeat (3) cyc(1'b1, 1'b1, 8'hFF);
        hold(1'b1, 8'hFF, 300);
        // short glitch that reverts before a period boundary
        hold(1'b1, 8'hF0, 3);
        hold(1'b1, 8'hFF, 600);
        for (int j = 0; j < 45; j++) begin
            rp = 8'($urandom);
            rn = $urandom_range(1, 700);
            re = ($urandom_range(0, 7) != 0);
            hold(re, rp, rn);
        end
        hold(1'b1, 8'h00, 50);

        repeat (3) @(negedge clk);
        #2;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
